// File: rtl/sdr_rd_ctrl.sv
// sdr_rd_ctrl
//   Reads whole frames out of SDRAM in fixed-length bursts and streams the
//   returned words into the UDP transmit FIFO. A frame becomes readable once
//   the write side reports it complete (wr_done). Up to three completed
//   frames can be queued. A burst is only requested when the FIFO has room
//   for the whole burst. A burst that stalls is re-requested from the same
//   address.
//
// Ports
//   Sdr_clk        in   clock, all logic on the rising edge
//   Rst            in   asynchronous active-high reset
//   Sdr_init_done  in   SDRAM initialisation complete (only used in IDLE)
//   Sdr_busy       in   controller cannot accept a request this cycle
//   wr_done        in   one-cycle pulse: a full frame has been written
//   udp_wrusedw    in   UDP FIFO occupancy in words
//   App_rd_en      out  one-cycle read request
//   App_rd_addr    out  burst start address, valid with App_rd_en
//   Sdr_rd_en      in   read data valid strobe
//   Sdr_rd_dout    in   read data
//   fifo_wr_en     out  UDP FIFO write strobe (one cycle after Sdr_rd_en)
//   fifo_wr_data   out  UDP FIFO write data
//   frame_start    out  pulse with the first FIFO write of a frame
//   frame_done     out  pulse once the last burst of a frame has landed
//   rd_busy        out  high while a frame is being read
//   rd_err         out  sticky: burst timeout or stray read strobe seen

module sdr_rd_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 21,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 307200,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_LIMIT  = 3840,
  parameter int TIMEOUT     = 255
) (
  input  logic                  Sdr_clk,
  input  logic                  Rst,
  input  logic                  Sdr_init_done,
  input  logic                  Sdr_busy,
  input  logic                  wr_done,
  input  logic [11:0]           udp_wrusedw,
  output logic                  App_rd_en,
  output logic [ADDR_WIDTH-1:0] App_rd_addr,
  input  logic                  Sdr_rd_en,
  input  logic [DATA_WIDTH-1:0] Sdr_rd_dout,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  rd_busy,
  output logic                  rd_err
);

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int AW1 = ADDR_WIDTH + 1;

  localparam logic [BCW-1:0]        BURST_LAST   = BCW'(BURST_LEN - 1);
  localparam logic [TCW-1:0]        TIMEOUT_LAST = TCW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE         = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP   = ADDR_WIDTH'(BURST_LEN);
  // One bit wider than the address so a frame ending exactly at
  // 2^ADDR_WIDTH is still recognised.
  localparam logic [AW1-1:0]        END_ADDR     = AW1'(BASE_ADDR + FRAME_WORDS);
  localparam logic [12:0]           NEED         = 13'(BURST_LEN);
  localparam logic [12:0]           LIMIT        = 13'(FIFO_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    CHECK,
    REQ,
    WAIT_DATA,
    NEXT,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BCW-1:0]        burst_cnt;
  logic [TCW-1:0]        tmo_cnt;
  logic [1:0]            pending;
  logic                  first_word;

  logic strobe_ok;
  logic burst_last;
  logic timed_out;
  logic fifo_room;
  logic frame_end;
  logic pend_inc;
  logic pend_dec;

  // ---------------------------------------------------------------------
  // Status terms
  // ---------------------------------------------------------------------
  always_comb begin
    strobe_ok  = (state == WAIT_DATA) && Sdr_rd_en;
    burst_last = strobe_ok && (burst_cnt == BURST_LAST);
    // A burst completing on the final timeout cycle is accepted, not retried.
    timed_out  = (state == WAIT_DATA) && (tmo_cnt == TIMEOUT_LAST) && !burst_last;
    fifo_room  = ({1'b0, udp_wrusedw} + NEED) <= LIMIT;
    frame_end  = ({1'b0, addr} + AW1'(BURST_LEN)) == END_ADDR;
    pend_inc   = wr_done;
    pend_dec   = (state == NEXT) && frame_end;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and request/handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    App_rd_en   = 1'b0;
    App_rd_addr = '0;
    frame_done  = 1'b0;
    rd_busy     = 1'b1;

    unique case (state)
      IDLE: begin
        rd_busy = 1'b0;
        if (Sdr_init_done) begin
          state_nxt = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        rd_busy = 1'b0;
        if (pending != 2'd0) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (fifo_room) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        App_rd_addr = addr;
        if (!Sdr_busy) begin
          App_rd_en = 1'b1;
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (burst_last) begin
          state_nxt = NEXT;
        end else if (timed_out) begin
          state_nxt = REQ;
        end
      end
      NEXT: begin
        state_nxt = frame_end ? DONE : CHECK;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = WAIT_FRAME;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Burst address
  // ---------------------------------------------------------------------
  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      addr <= BASE;
    end else if (state == NEXT) begin
      addr <= addr + BURST_STEP;
    end else if (state == DONE) begin
      addr <= BASE;
    end
  end

  // ---------------------------------------------------------------------
  // Burst word counter and data-wait timer; both restart on retry
  // ---------------------------------------------------------------------
  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      burst_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (state == WAIT_DATA) begin
      if (burst_last || timed_out) begin
        burst_cnt <= '0;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (Sdr_rd_en) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end
    end else begin
      burst_cnt <= '0;
      tmo_cnt   <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Pending-frame counter: saturates at 3, a simultaneous increment and
  // decrement cancel out.
  // ---------------------------------------------------------------------
  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      pending <= '0;
    end else begin
      unique case ({pend_inc, pend_dec})
        2'b10: if (pending != 2'd3) pending <= pending + 2'd1;
        2'b01: if (pending != 2'd0) pending <= pending - 2'd1;
        default: pending <= pending;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO forwarding, frame_start marker and sticky error
  // ---------------------------------------------------------------------
  // first_word marks that no word of the current frame has been forwarded
  // yet, so a retried first burst does not raise frame_start twice.
  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_start  <= 1'b0;
      first_word   <= 1'b1;
      rd_err       <= 1'b0;
    end else begin
      fifo_wr_en  <= strobe_ok;
      frame_start <= strobe_ok && first_word;
      if (strobe_ok) begin
        fifo_wr_data <= Sdr_rd_dout;
        first_word   <= 1'b0;
      end else if (state == DONE) begin
        first_word <= 1'b1;
      end
      if (timed_out || (Sdr_rd_en && (state != WAIT_DATA))) begin
        rd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdr_rd_ctrl.sv
// Testbench for sdr_rd_ctrl. Stimulus pushes the expected read requests
// into a queue; a monitor pops and compares them, and hands each one to a
// responder that returns random data words. Each returned word is queued as
// an expected FIFO write, which the monitor compares against the DUT.
module tb_sdr_rd_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 21;
  localparam int BL   = 8;
  localparam int FW   = 32;
  localparam int BASE = 32'h100;
  localparam int TMO  = 255;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   len;
    int unsigned   rst_after;
    bit            stray;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            fs;
    int unsigned   cyc;
  } word_t;

  logic          clk;
  logic          rst;
  logic          stim_rst   = 1'b0;
  logic          resp_rst   = 1'b0;
  logic          init_done  = 1'b0;
  logic          busy       = 1'b0;
  logic          wr_done    = 1'b0;
  logic [11:0]   usedw      = '0;
  logic          rd_en      = 1'b0;
  logic [DW-1:0] rd_dout    = '0;
  logic          app_en;
  logic [AW-1:0] app_addr;
  logic          fwe;
  logic [DW-1:0] fwd;
  logic          fs;
  logic          fd;
  logic          rbusy;
  logic          rerr;

  req_t  exp_req_q[$];
  req_t  resp_q[$];
  word_t exp_word_q[$];

  int unsigned checks    = 0;
  int unsigned errors    = 0;
  int unsigned cyc       = 0;
  int unsigned req_cnt   = 0;
  int unsigned req_cyc   = 0;
  int unsigned fdone_cnt = 0;
  int unsigned word_cnt  = 0;
  bit          fs_armed  = 1'b1;

  assign rst = stim_rst | resp_rst;

  sdr_rd_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL),
    .FRAME_WORDS(FW),
    .BASE_ADDR  (BASE),
    .FIFO_LIMIT (3840),
    .TIMEOUT    (TMO)
  ) dut (
    .Sdr_clk      (clk),
    .Rst          (rst),
    .Sdr_init_done(init_done),
    .Sdr_busy     (busy),
    .wr_done      (wr_done),
    .udp_wrusedw  (usedw),
    .App_rd_en    (app_en),
    .App_rd_addr  (app_addr),
    .Sdr_rd_en    (rd_en),
    .Sdr_rd_dout  (rd_dout),
    .fifo_wr_en   (fwe),
    .fifo_wr_data (fwd),
    .frame_start  (fs),
    .frame_done   (fd),
    .rd_busy      (rbusy),
    .rd_err       (rerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge.
  initial begin
    req_t  r;
    word_t w;
    forever begin
      @(negedge clk);
      if (app_en) begin
        req_cnt++;
        req_cyc = cyc;
        chk("req_while_busy", busy, 0);
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request at %0h, required none", app_addr);
        end else begin
          r = exp_req_q.pop_front();
          chk("req_addr", app_addr, r.addr);
          resp_q.push_back(r);
        end
      end
      if (fwe) begin
        word_cnt++;
        if (exp_word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got fifo write %0h, required none", fwd);
        end else begin
          w = exp_word_q.pop_front();
          chk("fifo_data", fwd, w.data);
          chk("frame_start", fs, w.fs);
          chk("fifo_latency", cyc, w.cyc + 1);
        end
      end else if (fs) begin
        checks++;
        errors++;
        $display("FAIL frame_start_alone: got frame_start=1 without fifo_wr_en, required 0");
      end
      if (fd) fdone_cnt++;
    end
  end

  // Responder: behaves as the SDRAM controller read path.
  initial begin
    req_t r;
    forever begin
      wait (resp_q.size() > 0);
      r = resp_q.pop_front();
      if (r.stray) begin
        @(posedge clk); #1;
        rd_en   = 1'b1;
        rd_dout = $urandom;
        @(posedge clk); #1;
        rd_en = 1'b0;
      end else begin
        repeat (3) @(posedge clk);
        #1;
        for (int unsigned i = 0; i < r.len; i++) begin
          rd_en   = 1'b1;
          rd_dout = $urandom;
          exp_word_q.push_back('{data: rd_dout, fs: fs_armed, cyc: cyc});
          fs_armed = 1'b0;
          @(posedge clk); #1;
          if (r.rst_after != 0 && i + 1 == r.rst_after) break;
        end
        rd_en = 1'b0;
        if (r.rst_after != 0) begin
          @(posedge clk); #1;
          resp_rst = 1'b1;
          fs_armed = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          resp_rst = 1'b0;
        end else if (r.len == BL && int'(r.addr) == BASE + FW - BL) begin
          fs_armed = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int unsigned k = 0; k < FW / BL; k++)
      exp_req_q.push_back('{addr: AW'(BASE + k * BL), len: BL, rst_after: 0, stray: 1'b0});
  endtask

  task automatic push_req(input int unsigned a, input int unsigned len, input int unsigned ra);
    exp_req_q.push_back('{addr: AW'(a), len: len, rst_after: ra, stray: 1'b0});
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1;
    tick(1);
    wr_done = 1'b0;
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (fdone_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("frame_done_count", fdone_cnt, target);
    tick(3);
    chk("idle_after_frame", rbusy, 0);
    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("word_queue_drained", exp_word_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_app_rd_en"}, app_en, 0);
    chk({tag, "_app_rd_addr"}, app_addr, 0);
    chk({tag, "_fifo_wr_en"}, fwe, 0);
    chk({tag, "_fifo_wr_data"}, fwd, 0);
    chk({tag, "_frame_start"}, fs, 0);
    chk({tag, "_frame_done"}, fd, 0);
    chk({tag, "_rd_busy"}, rbusy, 0);
    chk({tag, "_rd_err"}, rerr, 0);
  endtask

  // Stimulus
  initial begin
    int unsigned base_cnt;
    int unsigned drop_cyc;
    int unsigned w0;
    int unsigned n;

    #1 stim_rst = 1'b1;
    #1 chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    stim_rst  = 1'b0;
    init_done = 1'b1;
    tick(5);
    chk("idle_no_frame", rbusy, 0);

    // Single frame, FIFO empty, controller always ready.
    push_frame();
    pulse_wr_done();
    wait_frames(1, 400);
    chk("no_err_clean_frame", rerr, 0);

    // FIFO threshold: 3833 + 8 > 3840 blocks, 3832 + 8 == 3840 passes.
    usedw = 12'd3833;
    base_cnt = req_cnt;
    push_frame();
    pulse_wr_done();
    tick(20);
    chk("fifo_full_no_req", req_cnt, base_cnt);
    chk("fifo_full_busy", rbusy, 1);
    usedw = 12'd3832;
    drop_cyc = cyc;
    tick(3);
    chk("req_after_room", req_cyc, drop_cyc + 1);
    chk("req_after_room_cnt", req_cnt, base_cnt + 1);
    wait_frames(2, 400);
    usedw = '0;

    // Controller busy for several cycles while a request is pending.
    busy = 1'b1;
    base_cnt = req_cnt;
    push_frame();
    pulse_wr_done();
    tick(7);
    chk("busy_no_req", req_cnt, base_cnt);
    chk("busy_in_req", rbusy, 1);
    busy = 1'b0;
    drop_cyc = cyc;
    tick(2);
    chk("req_when_busy_falls", req_cyc, drop_cyc);
    wait_frames(3, 400);

    // Four completed frames while idle: only three are queued.
    for (int unsigned k = 0; k < 3; k++) push_frame();
    for (int unsigned k = 0; k < 4; k++) begin
      pulse_wr_done();
      tick(1);
    end
    wait_frames(6, 1500);
    tick(100);
    chk("saturated_frames", fdone_cnt, 6);
    chk("saturated_idle", rbusy, 0);

    // Short burst: timeout, then retry of the same address.
    base_cnt = req_cnt;
    push_req(BASE, BL, 0);
    push_req(BASE + 8, 5, 0);
    push_req(BASE + 8, BL, 0);
    push_req(BASE + 16, BL, 0);
    push_req(BASE + 24, BL, 0);
    pulse_wr_done();
    n = 0;
    while (req_cnt < base_cnt + 2 && n < 200) begin
      tick(1);
      n++;
    end
    chk("short_burst_requested", req_cnt, base_cnt + 2);
    tick(100);
    chk("no_err_before_timeout", rerr, 0);
    chk("no_retry_before_timeout", req_cnt, base_cnt + 2);
    wait_frames(7, 800);
    chk("err_after_timeout", rerr, 1);

    // Reset in the middle of the second burst (after 12 words).
    w0 = word_cnt;
    push_req(BASE, BL, 0);
    push_req(BASE + 8, BL, 4);
    push_req(BASE + 16, BL, 0);
    push_req(BASE + 24, BL, 0);
    pulse_wr_done();
    n = 0;
    while (!resp_rst && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("mid_reset_seen", resp_rst, 1);
    chk_outputs_zero("mid_reset");
    chk("words_before_reset", word_cnt - w0, 12);
    exp_req_q.delete();
    n = 0;
    while (resp_rst && n < 20) begin
      tick(1);
      n++;
    end
    chk("mid_reset_released", resp_rst, 0);
    base_cnt = req_cnt;
    tick(30);
    chk("no_req_after_reset", req_cnt, base_cnt);
    chk("idle_after_reset", rbusy, 0);
    fdone_cnt = 7;
    push_frame();
    pulse_wr_done();
    wait_frames(8, 400);
    chk("no_err_after_reset_frame", rerr, 0);

    // Stray strobe outside WAIT_DATA: flagged, never forwarded.
    w0 = word_cnt;
    resp_q.push_back('{addr: '0, len: 1, rst_after: 0, stray: 1'b1});
    tick(5);
    chk("stray_sets_err", rerr, 1);
    chk("stray_not_forwarded", word_cnt, w0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdr_rd_ctrl.md
SDR_RD_CTRL -- requirements
Module: sdr_rd_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, SDRAM word width; ADDR_WIDTH, 21, word address width; BURST_LEN, 8, words per read request; FRAME_WORDS, 307200, words per frame; BASE_ADDR, 0, frame start address; FIFO_LIMIT, 3840, maximum udp_wrusedw occupancy after a burst lands; TIMEOUT, 255, data-wait cycles before re-request.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports SHALL be:
- Sdr_clk  in  1  SDRAM controller clock; all logic on rising edge
- Rst  in  1  async active-high reset
- Sdr_init_done  in  1  SDRAM initialisation complete (level)
- Sdr_busy  in  1  controller cannot accept a request
- wr_done  in  1  one-cycle pulse; one full frame has been written to SDRAM
- udp_wrusedw  in  12  UDP FIFO occupancy, words
- App_rd_en  out  1  one-cycle read request
- App_rd_addr  out  ADDR_WIDTH  burst start address, valid with App_rd_en
- Sdr_rd_en  in  1  read data valid strobe
- Sdr_rd_dout  in  DATA_WIDTH  read data
- fifo_wr_en  out  1  UDP FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  UDP FIFO write data
- frame_start  out  1  one-cycle pulse with the first word of a frame
- frame_done  out  1  one-cycle pulse after the last word of a frame
- rd_busy  out  1  high outside IDLE and WAIT_FRAME
- rd_err  out  1  sticky; timeout or stray strobe seen

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_FRAME, CHECK, REQ, WAIT_DATA, NEXT, DONE.
REQ-004 IDLE SHALL go to WAIT_FRAME when Sdr_init_done=1; Sdr_init_done SHALL be ignored in all other states.
REQ-005 A 2-bit pending-frame counter SHALL increment on wr_done, saturate at 3, and decrement on entry to DONE; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-006 WAIT_FRAME SHALL go to CHECK when pending>0.
REQ-007 CHECK SHALL go to REQ when udp_wrusedw + BURST_LEN <= FIFO_LIMIT, evaluated at 13 bits; otherwise it SHALL stay in CHECK.
REQ-008 REQ SHALL assert App_rd_en for exactly one cycle, with App_rd_addr = current address, in the first cycle Sdr_busy=0, and then go to WAIT_DATA; while Sdr_busy=1 it SHALL wait with App_rd_en=0.
REQ-009 WAIT_DATA SHALL count Sdr_rd_en strobes and go to NEXT on the BURST_LEN-th strobe.
REQ-010 If TIMEOUT cycles pass in WAIT_DATA without completing the burst, the block SHALL set rd_err, discard the partial count, and return to REQ with the same address; words already forwarded SHALL NOT be recalled.
REQ-011 NEXT SHALL add BURST_LEN to the address; if the offset then equals FRAME_WORDS it SHALL go to DONE, otherwise to CHECK.
REQ-012 DONE SHALL pulse frame_done for one cycle, reset the address to BASE_ADDR, and go to WAIT_FRAME.
REQ-013 Every Sdr_rd_en in WAIT_DATA SHALL produce fifo_wr_en=1 and fifo_wr_data=Sdr_rd_dout exactly 1 cycle later (registered).
REQ-014 Sdr_rd_en in any other state SHALL NOT be forwarded and SHALL set rd_err.
REQ-015 frame_start SHALL coincide with the fifo_wr_en for offset 0 of each frame.
REQ-016 The address SHALL be ADDR_WIDTH wide, and BASE_ADDR+FRAME_WORDS SHALL NOT exceed 2^ADDR_WIDTH, so no wrap occurs within a frame.
REQ-017 FRAME_WORDS SHALL be a multiple of BURST_LEN.

Reset
REQ-018 While Rst=1, all outputs SHALL be 0; the state SHALL be IDLE; the address SHALL be BASE_ADDR; pending, burst and timeout counters SHALL be 0; rd_err SHALL be 0.
REQ-019 Rst asserted mid-burst SHALL abort immediately, with no further App_rd_en or fifo_wr_en until a new frame is pending after reset release.

Verification (FRAME_WORDS=32, BURST_LEN=8, BASE_ADDR=0x100)
REQ-020 Init 1, one wr_done, udp_wrusedw=0, responder returns 8 strobes 3 cycles after each request:
- App_rd_en pulses at 0x100, 0x108, 0x110, 0x118
- 32 fifo_wr_en; frame_start on the first; one frame_done; FSM back in WAIT_FRAME
REQ-021 udp_wrusedw=3833 in CHECK -> no App_rd_en; drop to 3832 -> request issued next cycle.
REQ-022 Sdr_busy held high 5 cycles in REQ -> App_rd_en in the cycle Sdr_busy falls, single pulse, address unchanged.
REQ-023 Responder returns only 5 of 8 words -> after 255 cycles rd_err=1 and a re-request at the same address; the full 8 words then advance the address.
REQ-024 4 wr_done pulses while idle -> pending saturates at 3; exactly 3 frames of 32 words are read; then idle.
REQ-025 Rst raised after 12 of 32 words -> outputs 0 at once; after release plus wr_done, reading restarts at 0x100.
